fetch_unit: RTL and testbench

- Parametrised, decoupled successor to the single-cycle pc_reg/pc-adder/instr_mem front end; replaces the combinational PC path.
- Issues word fetches to an instruction memory over a request/grant and response handshake, tolerating variable response latency.
- Buffers returned instructions, tagged with their PC, in a FIFO_DEPTH prefetch queue.
- Supports PC redirect (branch/jump) with flush of queued and in-flight fetches; feeds decode through a valid/ready interface.

---
 rtl/fetch_pkg.sv | 20 ++
 rtl/fetch_fifo.sv | 49 ++++
 rtl/fetch_unit.sv | 135 +++++++++++++
 tb/tb_fetch_unit.sv | 359 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the decoupled instruction fetch front end.
package fetch_pkg;

  localparam int unsigned INSTR_BYTES  = 4;
  localparam int unsigned FETCH_ADDR_W = 32;
  localparam int unsigned FETCH_DATA_W = 32;

  localparam logic [FETCH_ADDR_W-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

  typedef struct packed {
    logic [FETCH_ADDR_W-1:0] pc;
    logic [FETCH_DATA_W-1:0] instr;
  } fetch_entry_t;

  // Counter width able to hold 0..depth inclusive.
  function automatic int unsigned count_width(input int unsigned depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Prefetch queue of PC-tagged instructions; flush beats push/pop, no bypass.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  localparam int unsigned CW = count_width(DEPTH),
  localparam int unsigned PW = $clog2(DEPTH)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush,
  input  logic         push,
  input  fetch_entry_t wdata,
  input  logic         pop,
  output fetch_entry_t rdata,
  output logic [CW-1:0] count
);

  fetch_entry_t  mem [DEPTH];
  logic [PW-1:0] wptr;
  logic [PW-1:0] rptr;
  logic [CW-1:0] cnt;
  logic          do_push;
  logic          do_pop;

  assign do_pop  = pop && (cnt != '0);
  assign do_push = push && ((cnt != CW'(DEPTH)) || do_pop);

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wptr <= '0;
      rptr <= '0;
      cnt  <= '0;
    end else begin
      if (do_push) wptr <= wptr + PW'(1);
      if (do_pop)  rptr <= rptr + PW'(1);
      cnt <= cnt + CW'(do_push) - CW'(do_pop);
    end
  end

  // Storage is not reset; only entries below count are ever observed.
  always_ff @(posedge clk) begin
    if (do_push && !flush && !rst) mem[wptr] <= wdata;
  end

  assign rdata = mem[rptr];
  assign count = cnt;

endmodule

// File: rtl/fetch_unit.sv
// Decoupled instruction fetch: credit-limited imem requests, prefetch queue, redirect flush.
// Optional performance counters are built when FETCH_PERF_EN is defined.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = FETCH_DATA_W,
  parameter int unsigned ADDR_WIDTH = FETCH_ADDR_W,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC = ADDR_WIDTH'(RESET_PC_DEFAULT)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  redirect_i,
  input  logic [ADDR_WIDTH-1:0] redirect_pc_i,
  output logic                  imem_req_o,
  output logic [ADDR_WIDTH-1:0] imem_addr_o,
  input  logic                  imem_gnt_i,
  input  logic                  imem_rvalid_i,
  input  logic [DATA_WIDTH-1:0] imem_rdata_i,
  output logic                  instr_valid_o,
  output logic [DATA_WIDTH-1:0] instr_o,
  output logic [ADDR_WIDTH-1:0] instr_pc_o,
  input  logic                  instr_ready_i,
  output logic [31:0]           perf_fetched_o,
  output logic [31:0]           perf_flushed_o
);

  localparam int unsigned CW = count_width(FIFO_DEPTH);

  logic [ADDR_WIDTH-1:0] fetch_pc;
  logic [ADDR_WIDTH-1:0] resp_pc;
  logic [ADDR_WIDTH-1:0] redirect_target;
  logic [CW-1:0]         inflight;
  logic [CW-1:0]         drop_cnt;
  logic [CW-1:0]         live;
  logic [CW-1:0]         q_count;
  logic [CW:0]           occupancy;
  logic                  req;
  logic                  fire;
  logic                  resp;
  logic                  drop;
  logic                  push;
  logic                  pop;
  fetch_entry_t          push_entry;
  fetch_entry_t          head;
  logic                  unused_pc_lsbs;

  assign redirect_target = {redirect_pc_i[ADDR_WIDTH-1:2], 2'b00};
  assign unused_pc_lsbs  = ^redirect_pc_i[1:0];

  // Queue slots already spoken for: entries held plus responses still owed to us.
  assign live      = inflight - drop_cnt;
  assign occupancy = {1'b0, q_count} + {1'b0, live};

  assign req  = !rst && !redirect_i
             && (occupancy < (CW+1)'(FIFO_DEPTH))
             && (inflight < CW'(FIFO_DEPTH));
  assign fire = req && imem_gnt_i;
  // Responses with nothing outstanding belong to requests issued before reset.
  assign resp = imem_rvalid_i && (inflight != '0);
  assign drop = resp && (drop_cnt != '0);
  assign push = resp && !drop && !redirect_i;
  assign pop  = instr_valid_o && instr_ready_i && !redirect_i;

  always_comb begin
    push_entry       = '0;
    push_entry.pc    = FETCH_ADDR_W'(resp_pc);
    push_entry.instr = FETCH_DATA_W'(imem_rdata_i);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc <= RESET_PC;
      resp_pc  <= RESET_PC;
      inflight <= '0;
      drop_cnt <= '0;
    end else begin
      inflight <= inflight + CW'(fire) - CW'(resp);
      if (redirect_i) begin
        fetch_pc <= redirect_target;
        resp_pc  <= redirect_target;
        drop_cnt <= inflight - CW'(resp);
      end else begin
        if (fire) fetch_pc <= fetch_pc + ADDR_WIDTH'(INSTR_BYTES);
        if (drop) drop_cnt <= drop_cnt - CW'(1);
        if (push) resp_pc  <= resp_pc + ADDR_WIDTH'(INSTR_BYTES);
      end
    end
  end

  fetch_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .flush (redirect_i),
    .push  (push),
    .wdata (push_entry),
    .pop   (pop),
    .rdata (head),
    .count (q_count)
  );

  assign imem_req_o    = req;
  assign imem_addr_o   = fetch_pc;
  assign instr_valid_o = (q_count != '0);
  assign instr_o       = DATA_WIDTH'(head.instr);
  assign instr_pc_o    = ADDR_WIDTH'(head.pc);

`ifdef FETCH_PERF_EN
  logic [31:0] perf_fetched_q;
  logic [31:0] perf_flushed_q;
  logic [32:0] flushed_sum;

  assign flushed_sum = {1'b0, perf_flushed_q} + 33'(occupancy);

  // Saturating counters: deliveries and work discarded by redirects.
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_fetched_q <= '0;
      perf_flushed_q <= '0;
    end else begin
      if (pop && (perf_fetched_q != '1)) perf_fetched_q <= perf_fetched_q + 32'd1;
      if (redirect_i) perf_flushed_q <= flushed_sum[32] ? '1 : flushed_sum[31:0];
    end
  end

  assign perf_fetched_o = perf_fetched_q;
  assign perf_flushed_o = perf_flushed_q;
`else
  assign perf_fetched_o = 32'd0;
  assign perf_flushed_o = 32'd0;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios plus random traffic against a queue-based model.
module tb_fetch_unit;

  localparam int unsigned DEPTH = 4;
`ifdef FETCH_PERF_EN
  localparam bit PERF_EN = 1'b1;
`else
  localparam bit PERF_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        redirect_i;
  logic [31:0] redirect_pc_i;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_gnt_i;
  logic        imem_rvalid_i;
  logic [31:0] imem_rdata_i;
  logic        instr_valid_o;
  logic [31:0] instr_o;
  logic [31:0] instr_pc_o;
  logic        instr_ready_i;
  logic [31:0] perf_fetched_o;
  logic [31:0] perf_flushed_o;

  fetch_unit #(
    .DATA_WIDTH (32),
    .ADDR_WIDTH (32),
    .FIFO_DEPTH (DEPTH),
    .RESET_PC   (32'h0000_0000)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .redirect_i     (redirect_i),
    .redirect_pc_i  (redirect_pc_i),
    .imem_req_o     (imem_req_o),
    .imem_addr_o    (imem_addr_o),
    .imem_gnt_i     (imem_gnt_i),
    .imem_rvalid_i  (imem_rvalid_i),
    .imem_rdata_i   (imem_rdata_i),
    .instr_valid_o  (instr_valid_o),
    .instr_o        (instr_o),
    .instr_pc_o     (instr_pc_o),
    .instr_ready_i  (instr_ready_i),
    .perf_fetched_o (perf_fetched_o),
    .perf_flushed_o (perf_flushed_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
  } m_ent_t;

  // Reference state: delivered-instruction queue plus one liveness flag per outstanding request.
  m_ent_t      mq[$];
  bit          live_q[$];
  logic [31:0] m_fetch_pc = 32'h0;
  logic [31:0] m_resp_pc  = 32'h0;
  logic [31:0] m_fetched  = 32'h0;
  logic [31:0] m_flushed  = 32'h0;

  // Memory side: in-order responses with random latency.
  logic [31:0] mem_addr_q[$];
  int          mem_due_q[$];
  int          last_due = 0;
  int          lat_min  = 1;
  int          lat_max  = 1;

  // Next-cycle stimulus.
  bit          c_rst   = 1'b0;
  bit          c_redir = 1'b0;
  logic [31:0] c_rpc   = 32'h0;
  bit          c_gnt   = 1'b0;
  bit          c_ready = 1'b0;

  logic        s_req;
  logic [31:0] s_addr;
  logic        s_valid;
  logic [31:0] s_pc;
  logic [31:0] s_instr;

  int cyc      = 0;
  int n_grants = 0;
  int n_checks = 0;
  int n_fail   = 0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  function automatic logic [31:0] sat_add(input logic [31:0] a, input int unsigned b);
    logic [32:0] s;
    s = {1'b0, a} + 33'(b);
    return s[32] ? 32'hFFFF_FFFF : s[31:0];
  endfunction

  function automatic int count_live();
    int n;
    n = 0;
    foreach (live_q[k]) if (live_q[k]) n++;
    return n;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic timeout_fail(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: wait bound expired (cycle %0d)", name, cyc);
  endtask

  // One clock cycle: drive, compare against the model, then advance the model.
  task automatic step();
    int          nlive;
    bit          exp_req;
    bit          exp_valid;
    bit          live_resp;
    bit          granted;
    int          due;
    logic [31:0] tgt;
    m_ent_t      e;

    @(negedge clk);
    rst           = c_rst;
    redirect_i    = c_redir;
    redirect_pc_i = c_rpc;
    imem_gnt_i    = c_gnt;
    instr_ready_i = c_ready;
    if (!c_rst && (mem_addr_q.size() > 0) && (mem_due_q[0] <= cyc)) begin
      imem_rvalid_i = 1'b1;
      imem_rdata_i  = mem_word(mem_addr_q[0]);
    end else begin
      imem_rvalid_i = 1'b0;
      imem_rdata_i  = $urandom;
    end
    #1;
    s_req   = imem_req_o;
    s_addr  = imem_addr_o;
    s_valid = instr_valid_o;
    s_pc    = instr_pc_o;
    s_instr = instr_o;

    nlive     = count_live();
    exp_req   = !c_rst && !c_redir && ((mq.size() + nlive) < DEPTH) && (live_q.size() < DEPTH);
    exp_valid = (mq.size() > 0);

    chk("imem_req", 32'(s_req), 32'(exp_req));
    if (exp_req) chk("imem_addr", s_addr, m_fetch_pc);
    chk("instr_valid", 32'(s_valid), 32'(exp_valid));
    if (exp_valid) begin
      chk("instr_pc", s_pc, mq[0].pc);
      chk("instr", s_instr, mq[0].instr);
    end
    chk("perf_fetched", perf_fetched_o, PERF_EN ? m_fetched : 32'h0);
    chk("perf_flushed", perf_flushed_o, PERF_EN ? m_flushed : 32'h0);

    if (imem_rvalid_i) begin
      void'(mem_addr_q.pop_front());
      void'(mem_due_q.pop_front());
    end
    granted = (s_req === 1'b1) && c_gnt;
    if (granted) begin
      n_grants++;
      due = cyc + $urandom_range(lat_max, lat_min);
      if (due <= last_due) due = last_due + 1;
      last_due = due;
      mem_addr_q.push_back(s_addr);
      mem_due_q.push_back(due);
    end

    if (c_rst) begin
      mq.delete();
      live_q.delete();
      mem_addr_q.delete();
      mem_due_q.delete();
      last_due   = cyc;
      m_fetch_pc = 32'h0;
      m_resp_pc  = 32'h0;
      m_fetched  = 32'h0;
      m_flushed  = 32'h0;
    end else if (c_redir) begin
      m_flushed = sat_add(m_flushed, mq.size() + nlive);
      if (imem_rvalid_i && (live_q.size() > 0)) void'(live_q.pop_front());
      foreach (live_q[k]) live_q[k] = 1'b0;
      mq.delete();
      tgt        = c_rpc & 32'hFFFF_FFFC;
      m_fetch_pc = tgt;
      m_resp_pc  = tgt;
      if (granted) live_q.push_back(1'b1);
    end else begin
      live_resp = 1'b0;
      if (imem_rvalid_i && (live_q.size() > 0)) live_resp = live_q.pop_front();
      if (live_resp) begin
        n_checks++;
        assert (mq.size() < DEPTH)
        else begin
          n_fail++;
          $display("FAIL credit: live response with %0d queued, depth %0d (cycle %0d)", mq.size(), DEPTH, cyc);
        end
      end
      if (exp_valid && c_ready) begin
        void'(mq.pop_front());
        if (m_fetched != 32'hFFFF_FFFF) m_fetched = m_fetched + 32'd1;
      end
      if (live_resp) begin
        e.pc    = m_resp_pc;
        e.instr = imem_rdata_i;
        mq.push_back(e);
        m_resp_pc = m_resp_pc + 32'd4;
      end
      if (granted) begin
        live_q.push_back(1'b1);
        m_fetch_pc = m_fetch_pc + 32'd4;
      end
    end
    cyc++;
  endtask

  task automatic do_reset();
    c_rst   = 1'b1;
    c_redir = 1'b0;
    step();
    c_rst = 1'b0;
  endtask

  task automatic expect_next_pc(input string name, input logic [31:0] pc);
    int k;
    for (k = 0; k < 20; k++) begin
      step();
      if (s_valid === 1'b1) break;
    end
    if (k == 20) timeout_fail(name);
    else chk(name, s_pc, pc);
  endtask

  initial begin
    rst           = 1'b1;
    redirect_i    = 1'b0;
    redirect_pc_i = 32'h0;
    imem_gnt_i    = 1'b0;
    imem_rvalid_i = 1'b0;
    imem_rdata_i  = 32'h0;
    instr_ready_i = 1'b0;
    repeat (3) @(posedge clk);

    // Streaming: gnt=1, latency 1, ready=1.
    c_gnt = 1'b1; c_ready = 1'b1; lat_min = 1; lat_max = 1;
    for (int c = 0; c < 8; c++) begin
      step();
      chk("stream_req", 32'(s_req), 32'h1);
      chk("stream_addr", s_addr, 32'(4 * c));
      if (c >= 2) begin
        chk("stream_valid", 32'(s_valid), 32'h1);
        chk("stream_pc", s_pc, 32'(4 * (c - 2)));
      end
    end

    // Decode stalled: credit limit caps grants at the queue depth.
    do_reset();
    c_ready = 1'b0; c_gnt = 1'b1;
    n_grants = 0;
    repeat (10) step();
    chk("stall_grants", 32'(n_grants), 32'd4);
    chk("stall_req_low", 32'(s_req), 32'h0);
    c_ready = 1'b1;
    step();
    c_ready = 1'b0;
    n_grants = 0;
    repeat (5) step();
    chk("one_pop_one_grant", 32'(n_grants), 32'd1);

    // Grant withheld: address held stable.
    do_reset();
    c_ready = 1'b1; c_gnt = 1'b1;
    step();
    step();
    c_gnt = 1'b0;
    repeat (3) begin
      step();
      chk("hold_req", 32'(s_req), 32'h1);
      chk("hold_addr", s_addr, 32'h8);
    end
    c_gnt = 1'b1;
    step();
    chk("grant_addr", s_addr, 32'h8);
    step();
    chk("after_grant_addr", s_addr, 32'hC);

    // Redirect with queued and in-flight work, coinciding with a pop and a response.
    do_reset();
    c_ready = 1'b0; c_gnt = 1'b1; lat_min = 3; lat_max = 3;
    begin
      int k;
      for (k = 0; k < 20; k++) begin
        step();
        if ((mq.size() == 2) && (count_live() == 2)) break;
      end
      if (k == 20) timeout_fail("redirect_setup");
    end
    c_redir = 1'b1; c_rpc = 32'h0000_0103; c_ready = 1'b1;
    step();
    c_redir = 1'b0;
    step();
    chk("redirect_valid_cleared", 32'(s_valid), 32'h0);
    chk("redirect_new_addr", s_addr, 32'h100);
    chk("redirect_perf_flushed", perf_flushed_o, PERF_EN ? 32'd4 : 32'd0);
    chk("redirect_perf_fetched", perf_fetched_o, 32'd0);
    expect_next_pc("redirect_pc0", 32'h100);
    expect_next_pc("redirect_pc1", 32'h104);

    // PC wrap, then reset mid-burst.
    do_reset();
    c_gnt = 1'b1; c_ready = 1'b1; lat_min = 1; lat_max = 1;
    c_redir = 1'b1; c_rpc = 32'hFFFF_FFF8;
    step();
    c_redir = 1'b0;
    step();
    chk("wrap_addr0", s_addr, 32'hFFFF_FFF8);
    step();
    chk("wrap_addr1", s_addr, 32'hFFFF_FFFC);
    step();
    chk("wrap_addr2", s_addr, 32'h0000_0000);
    expect_next_pc("wrap_pc", 32'hFFFF_FFFC);
    c_ready = 1'b0;
    repeat (2) step();
    c_rst = 1'b1;
    step();
    chk("reset_req_low", 32'(s_req), 32'h0);
    c_rst = 1'b0;
    step();
    chk("post_reset_valid", 32'(s_valid), 32'h0);
    chk("post_reset_req", 32'(s_req), 32'h1);
    chk("post_reset_addr", s_addr, 32'h0);

    // Random traffic.
    lat_min = 1; lat_max = 4;
    for (int i = 0; i < 3000; i++) begin
      c_gnt   = ($urandom_range(9, 0) < 7);
      c_ready = ($urandom_range(9, 0) < 6);
      c_redir = ($urandom_range(99, 0) < 3);
      c_rpc   = ($urandom_range(3, 0) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(15, 0))) : 32'($urandom);
      c_rst   = ($urandom_range(999, 0) < 3);
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
